// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and shared-memory ports of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [3:0]            dm_be_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic                  dm_gnt_o;
  logic                  dm_rvalid_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  busy_o;

  // master: the arbiter itself; slave: pipeline stages plus memory model
  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output busy_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority arbiter of fetch and data ports onto one memory
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]            state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  dm_rvalid_q, dm_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic idle;
  logic grant_d;
  logic grant_i;

  // fetch overrides data only once it has watched STARVE_MAX data grants go by
  assign idle    = (state_q == IDLE);
  assign grant_d = idle && bus.dm_req_i && !(bus.if_req_i && (starve_cnt_q == STARVE_LIM));
  assign grant_i = idle && bus.if_req_i && !grant_d;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_be_d    = bus.dm_be_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          if (!bus.if_req_i) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (grant_i) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'hF;
          mem_addr_d   = bus.if_addr_i;
          mem_wdata_d  = '0;
          starve_cnt_d = 4'd0;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack_i) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack_i) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          dm_rvalid_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign bus.if_gnt_o    = grant_i;
  assign bus.dm_gnt_o    = grant_d;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rvalid_o = dm_rvalid_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.busy_o      = !idle;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_be_i     = 4'h0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;

    // reset state
    #3;
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 0);
    chk("rst_mem_be", bus.mem_be_o, 0);
    #4 rst_n = 1'b1;
    tick();

    // single load, ack in cycle 1
    bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h100; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF;
    #1;
    chk("load_dm_gnt", bus.dm_gnt_o, 1);
    chk("load_if_gnt", bus.if_gnt_o, 0);
    tick();
    bus.dm_req_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("load_mem_req", bus.mem_req_o, 1);
    chk("load_mem_addr", bus.mem_addr_o, 32'h100);
    chk("load_mem_we", bus.mem_we_o, 0);
    chk("load_busy", bus.busy_o, 1);
    chk("load_gnt_busy", bus.dm_gnt_o, 0);
    tick();
    bus.mem_ack_i = 1'b0;
    chk("load_rvalid", bus.dm_rvalid_o, 1);
    chk("load_rdata", bus.dm_rdata_o, 32'hDEADBEEF);
    chk("load_busy_low", bus.busy_o, 0);
    chk("load_req_low", bus.mem_req_o, 0);
    chk("load_if_rvalid", bus.if_rvalid_o, 0);
    tick();
    chk("load_rvalid_pulse", bus.dm_rvalid_o, 0);

    // store with three request cycles
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h204;
    bus.dm_wdata_i = 32'h12345678; bus.dm_be_i = 4'b0011;
    #1;
    chk("store_gnt", bus.dm_gnt_o, 1);
    tick();
    bus.dm_req_i = 1'b0; bus.dm_addr_i = 32'hFFFF; bus.dm_wdata_i = '0; bus.dm_be_i = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hCAFEF00D;
      end
      #1;
      chk("store_req", bus.mem_req_o, 1);
      chk("store_addr", bus.mem_addr_o, 32'h204);
      chk("store_wdata", bus.mem_wdata_o, 32'h12345678);
      chk("store_be", bus.mem_be_o, 4'b0011);
      chk("store_we", bus.mem_we_o, 1);
      chk("store_no_rvalid", bus.dm_rvalid_o, 0);
      tick();
    end
    bus.mem_ack_i = 1'b0;
    chk("store_rvalid", bus.dm_rvalid_o, 1);
    chk("store_rdata_kept", bus.dm_rdata_o, 32'hDEADBEEF);
    tick();
    chk("store_rvalid_pulse", bus.dm_rvalid_o, 0);

    // priority: simultaneous requests, data wins, fetch follows in rvalid cycle
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h300;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    #1;
    chk("prio_dm_gnt", bus.dm_gnt_o, 1);
    chk("prio_if_gnt", bus.if_gnt_o, 0);
    tick();
    bus.dm_req_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h00000011;
    #1;
    chk("prio_if_wait", bus.if_gnt_o, 0);
    chk("prio_mem_addr", bus.mem_addr_o, 32'h300);
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    chk("prio_dm_rvalid", bus.dm_rvalid_o, 1);
    chk("prio_if_gnt_next", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h13579BDF;
    #1;
    chk("fetch_addr", bus.mem_addr_o, 32'h40);
    chk("fetch_be", bus.mem_be_o, 4'hF);
    chk("fetch_we", bus.mem_we_o, 0);
    chk("fetch_wdata", bus.mem_wdata_o, 0);
    tick();
    bus.mem_ack_i = 1'b0;
    chk("fetch_rvalid", bus.if_rvalid_o, 1);
    chk("fetch_rdata", bus.if_rdata_o, 32'h13579BDF);
    chk("fetch_dm_rdata_kept", bus.dm_rdata_o, 32'h00000011);
    tick();

    // starvation: both requests held, grants D D D D I repeating
    bus.dm_req_i = 1'b1; bus.if_req_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("starve_dm_gnt", bus.dm_gnt_o, (n % 5 == 4) ? 1'b0 : 1'b1);
      chk("starve_if_gnt", bus.if_gnt_o, (n % 5 == 4) ? 1'b1 : 1'b0);
      tick();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h1000 + n;
      tick();
      bus.mem_ack_i = 1'b0;
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0;
    tick();

    // reset mid-fetch
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
    #1;
    chk("rstmid_if_gnt", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 1'b0;
    chk("rstmid_busy", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req_async", bus.mem_req_o, 0);
    chk("rstmid_busy_async", bus.busy_o, 0);
    chk("rstmid_if_rdata", bus.if_rdata_o, 0);
    chk("rstmid_mem_addr", bus.mem_addr_o, 0);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("rstmid_no_rvalid", bus.if_rvalid_o, 0);
    chk("rstmid_idle", bus.busy_o, 0);
    chk("rstmid_rdata_zero", bus.if_rdata_o, 0);

    // stray ack in IDLE after a load has set up state
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h500;
    tick();
    bus.dm_req_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hA5A5A5A5;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("stray_setup_rdata", bus.dm_rdata_o, 32'hA5A5A5A5);
    tick();
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h77777777;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("stray_dm_rvalid", bus.dm_rvalid_o, 0);
    chk("stray_if_rvalid", bus.if_rvalid_o, 0);
    chk("stray_dm_rdata", bus.dm_rdata_o, 32'hA5A5A5A5);
    chk("stray_busy", bus.busy_o, 0);
    chk("stray_mem_req", bus.mem_req_o, 0);
    chk("stray_mem_addr", bus.mem_addr_o, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
